init_seq_ctrl: RTL and testbench
================================

Name: init_seq_ctrl

Overview:
- Parametrised initialisation sequencer for SPI display controllers.
- Walks an external init table of {delay_code, dc, data} entries and presents each byte to the SPI byte transmitter over a valid/ready handshake.
- Inserts a per-entry post-delay in units of TICK_CYCLES clocks, then waits for the SPI shifter to drain before signalling done.
- Replaces the hard-coded two-address delay scheme; the table length, data width, delay resolution and tick period are all generic, and the block supports start, abort and restart.

Parameters:
- INIT_LIST_LENGTH, 47: number of table entries; AW = max(1, clog2(INIT_LIST_LENGTH)).
- DATA_W, 8: payload width per entry.
- DELAY_W, 8: width of the per-entry delay code.
- TICK_CYCLES, 50000: clocks per delay tick; must be ≥ 1. With TICK_CYCLES = 1 the delay is exactly delay_code cycles (simulation).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins the sequence from IDLE or DONE.
- abort  in  1  stops the sequence and returns to IDLE.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE.
- rom_addr  out  AW  table index, registered.
- rom_data  in  DELAY_W+1+DATA_W  table entry {delay_code, dc, data}; valid one cycle after rom_addr changes.
- tx_valid  out  1  byte available to the SPI transmitter.
- tx_ready  in  1  transmitter accepts the byte; a transfer happens when tx_valid and tx_ready are both high.
- tx_data  out  DATA_W  byte to send.
- tx_dc  out  1  0 = command, 1 = data.
- spi_busy  in  1  transmitter still shifting.

Behaviour:
- Reset:
  - state = IDLE.
  - rom_addr = 0, tx_valid = 0, tx_data = 0, tx_dc = 0, busy = 0, done = 0.
  - Tick and delay counters = 0.
  - rst has priority over abort and start.
- States: IDLE, FETCH, SEND, DELAY, FLUSH, DONE.
- IDLE:
  - On start, go to FETCH next cycle with rom_addr = 0.
- FETCH:
  - Lasts exactly one cycle.
  - Latch rom_data into {dly, tx_dc, tx_data}.
  - Go to SEND.
  - A start pulse at cycle t gives the first tx_valid at t+2.
- SEND:
  - tx_valid = 1; tx_data and tx_dc are held stable until the handshake.
  - On handshake at cycle h, tx_valid drops at h+1.
  - Then:
    - If dly ≠ 0, go to DELAY.
    - If dly = 0 and rom_addr = INIT_LIST_LENGTH-1, go to FLUSH.
    - Otherwise increment rom_addr and go to FETCH; the next tx_valid is at h+2.
- DELAY:
  - Occupies exactly dly*TICK_CYCLES cycles, h+1 through h+dly*TICK_CYCLES.
  - The prescaler counts 0..TICK_CYCLES-1; on wrap the tick counter increments.
  - On reaching dly ticks: if this was the last entry, go to FLUSH; else increment rom_addr and go to FETCH.
  - The counter is cleared on every entry to DELAY.
  - The maximum delay dly = 2^DELAY_W-1 must not overflow; the tick counter is DELAY_W bits.
- FLUSH:
  - Wait for spi_busy = 0, sampled in this state; then go to DONE.
  - If spi_busy is already low, FLUSH lasts one cycle.
- DONE:
  - done = 1 and busy = 0; rom_addr holds its last value.
  - start returns to FETCH with rom_addr = 0 and done cleared next cycle.
- start while busy = 1 is ignored.
- abort in any state other than IDLE:
  - Next cycle: state = IDLE, tx_valid = 0, done = 0, rom_addr = 0, counters cleared.
  - An in-flight byte already handshaken is not recalled.
  - abort and start in the same cycle: abort wins.
  - abort in IDLE has no effect.
- INIT_LIST_LENGTH = 1:
  - AW = 1, rom_addr is always 0.
  - After the single handshake (and any delay), go directly to FLUSH.
- rom_addr never exceeds INIT_LIST_LENGTH-1; there is no wrap-around.
- tx_valid never drops without a handshake, except on abort or rst.

Test Plan:
- LENGTH=3, entries {0,0,CB},{0,1,39},{0,1,2C}, tx_ready=1, TICK_CYCLES=1, spi_busy=0; start at t=0:
  - tx_valid at t=2 (CB, dc=0), t=4 (39, dc=1), t=6 (2C, dc=1).
  - FLUSH at t=7; done=1 from t=8.
- Entry 0 has dly=5, TICK_CYCLES=2; handshake at h:
  - tx_valid low from h+1 to h+11; rom_addr=1 at h+11; next tx_valid at h+12.
- Backpressure: tx_ready held low 5 cycles after tx_valid rises:
  - tx_valid, tx_data and tx_dc stable throughout; exactly one handshake; rom_addr advances once.
- spi_busy held high 10 cycles after the last handshake:
  - done stays low; done rises one cycle after spi_busy falls.
- abort mid-DELAY (dly=100):
  - Next cycle busy=0, tx_valid=0, rom_addr=0.
  - A subsequent start replays entry 0 first.
- After done, start again:
  - done clears next cycle and the full sequence repeats identically.
- Synchronous rst asserted during SEND:
  - All outputs reach reset values the following cycle; start ignored while rst=1.

Source files
------------

// File: rtl/init_seq_ctrl.sv
// Initialisation sequencer for SPI display controllers: walks a {delay, dc, data}
// table, hands each byte to the SPI transmitter, waits per-entry delays, then drains.
module init_seq_ctrl #(
  parameter int INIT_LIST_LENGTH = 47,
  parameter int DATA_W           = 8,
  parameter int DELAY_W          = 8,
  parameter int TICK_CYCLES      = 50000,
  localparam int AW = (INIT_LIST_LENGTH > 1) ? $clog2(INIT_LIST_LENGTH) : 1,
  localparam int RW = DELAY_W + 1 + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     rom_addr,
  input  logic [RW-1:0]     rom_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_dc,
  input  logic              spi_busy
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(INIT_LIST_LENGTH - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_DELAY = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [DELAY_W-1:0]  r_dly;
  logic [DELAY_W-1:0]  r_tick_cnt;
  logic [PW-1:0]       r_presc;
  logic [AW-1:0]       r_rom_addr;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_dc;
  logic                r_tx_valid;
  logic                r_busy;
  logic                r_done;

  logic [DELAY_W-1:0]  w_rom_dly;
  logic                w_rom_dc;
  logic [DATA_W-1:0]   w_rom_data;
  logic                w_handshake;
  logic                w_last;
  logic                w_presc_wrap;
  logic                w_delay_end;

  assign w_rom_dly    = rom_data[RW-1 -: DELAY_W];
  assign w_rom_dc     = rom_data[DATA_W];
  assign w_rom_data   = rom_data[DATA_W-1:0];
  assign w_handshake  = r_tx_valid & tx_ready;
  assign w_last       = (r_rom_addr == LAST_ADDR);
  assign w_presc_wrap = (r_presc == PRESC_LAST);
  // r_dly is never zero while in DELAY, so dly-1 cannot underflow there.
  assign w_delay_end  = w_presc_wrap && (r_tick_cnt == (r_dly - DELAY_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dly      <= '0;
      r_tick_cnt <= '0;
      r_presc    <= '0;
      r_rom_addr <= '0;
      r_tx_data  <= '0;
      r_tx_dc    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      // A byte already accepted by the transmitter keeps shifting; only the sequence stops.
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_presc    <= '0;
      r_rom_addr <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_rom_addr <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_FETCH: begin
          r_dly      <= w_rom_dly;
          r_tx_dc    <= w_rom_dc;
          r_tx_data  <= w_rom_data;
          r_tx_valid <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (w_handshake) begin
            r_tx_valid <= 1'b0;
            if (r_dly != '0) begin
              r_state    <= S_DELAY;
              r_presc    <= '0;
              r_tick_cnt <= '0;
            end else if (w_last) begin
              r_state <= S_FLUSH;
            end else begin
              r_rom_addr <= r_rom_addr + AW'(1);
              r_state    <= S_FETCH;
            end
          end else begin
            r_tx_valid <= 1'b1;
          end
        end
        S_DELAY: begin
          if (w_delay_end) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
            if (w_last) begin
              r_state <= S_FLUSH;
            end else begin
              r_rom_addr <= r_rom_addr + AW'(1);
              r_state    <= S_FETCH;
            end
          end else if (w_presc_wrap) begin
            r_presc    <= '0;
            r_tick_cnt <= r_tick_cnt + DELAY_W'(1);
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        S_FLUSH: begin
          if (!spi_busy) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FLUSH;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rom_addr = r_rom_addr;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign tx_dc    = r_tx_dc;

endmodule

// File: tb/tb_init_seq_ctrl.sv
// Directed bench for init_seq_ctrl: a 3-entry table with a 2-cycle tick, plus a
// 1-entry table with a 1-cycle tick for the single-entry boundary.
module tb_init_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, abort = 1'b0, tx_ready = 1'b1, spi_busy = 1'b0;
  logic        busy, done, tx_valid, tx_dc;
  logic [1:0]  rom_addr;
  logic [16:0] rom_data;
  logic [7:0]  tx_data;
  logic [16:0] rom [0:2];

  logic        start1 = 1'b0;
  logic        busy1, done1, tx_valid1, tx_dc1;
  logic [0:0]  rom_addr1;
  logic [16:0] rom_data1 = 17'd0;
  logic [7:0]  tx_data1;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;

  assign rom_data = (rom_addr < 2'd3) ? rom[rom_addr] : 17'd0;

  init_seq_ctrl #(.INIT_LIST_LENGTH(3), .DATA_W(8), .DELAY_W(8), .TICK_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_dc(tx_dc), .spi_busy(spi_busy)
  );

  init_seq_ctrl #(.INIT_LIST_LENGTH(1), .DATA_W(8), .DELAY_W(8), .TICK_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .busy(busy1), .done(done1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
    .tx_data(tx_data1), .tx_dc(tx_dc1), .spi_busy(spi_busy)
  );

  always @(posedge clk) if (tx_valid && tx_ready) hs_cnt++;

  task cyc();
    @(posedge clk);
    #1;
  endtask

  task load_default();
    rom[0] = {8'd0, 1'b0, 8'hCB};
    rom[1] = {8'd0, 1'b1, 8'h39};
    rom[2] = {8'd0, 1'b1, 8'h2C};
  endtask

  task do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task test_reset();
    rst = 1'b1; start = 1'b1;
    cyc(); cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    checks++; if (rom_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
    checks++; if (tx_dc !== 1'b0) begin errors++; $display("FAIL reset_dc: got %b want 0", tx_dc); end
    rst = 1'b0; start = 1'b0;
  endtask

  task test_basic_and_restart();
    logic [7:0] exp_d [0:2];
    logic       exp_dc [0:2];
    exp_d  = '{8'hCB, 8'h39, 8'h2C};
    exp_dc = '{1'b0, 1'b1, 1'b1};
    load_default();
    do_reset();
    tx_ready = 1'b1; spi_busy = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1; cyc(); start = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0 || tx_valid !== 1'b0 || rom_addr !== 2'd0) begin
        errors++; $display("FAIL seq_fetch0 pass%0d: got busy=%b done=%b valid=%b addr=%0d want 1 0 0 0", pass, busy, done, tx_valid, rom_addr);
      end
      for (int k = 0; k < 3; k++) begin
        cyc();
        checks++; if (tx_valid !== 1'b1 || tx_data !== exp_d[k] || tx_dc !== exp_dc[k] || rom_addr !== 2'(k)) begin
          errors++; $display("FAIL seq_send%0d pass%0d: got valid=%b data=%h dc=%b addr=%0d want 1 %h %b %0d", k, pass, tx_valid, tx_data, tx_dc, rom_addr, exp_d[k], exp_dc[k], k);
        end
        cyc();
        checks++; if (tx_valid !== 1'b0 || rom_addr !== 2'((k < 2) ? k + 1 : 2) || busy !== 1'b1 || done !== 1'b0) begin
          errors++; $display("FAIL seq_gap%0d pass%0d: got valid=%b addr=%0d busy=%b done=%b", k, pass, tx_valid, rom_addr, busy, done);
        end
      end
      cyc();
      checks++; if (done !== 1'b1 || busy !== 1'b0 || rom_addr !== 2'd2) begin
        errors++; $display("FAIL seq_done pass%0d: got done=%b busy=%b addr=%0d want 1 0 2", pass, done, busy, rom_addr);
      end
    end
  endtask

  task test_delay();
    load_default();
    rom[0] = {8'd5, 1'b0, 8'hA5};
    do_reset();
    tx_ready = 1'b1; spi_busy = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL dly_send0: got valid=%b data=%h want 1 a5", tx_valid, tx_data); end
    for (int i = 1; i <= 10; i++) begin
      start = (i == 3);
      cyc();
      checks++; if (tx_valid !== 1'b0 || rom_addr !== 2'd0 || busy !== 1'b1) begin
        errors++; $display("FAIL dly_wait h+%0d: got valid=%b addr=%0d busy=%b want 0 0 1", i, tx_valid, rom_addr, busy);
      end
    end
    start = 1'b0;
    cyc();
    checks++; if (tx_valid !== 1'b0 || rom_addr !== 2'd1) begin errors++; $display("FAIL dly_fetch1: got valid=%b addr=%0d want 0 1", tx_valid, rom_addr); end
    cyc();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h39) begin errors++; $display("FAIL dly_send1: got valid=%b data=%h want 1 39", tx_valid, tx_data); end
    cyc(); cyc(); cyc(); cyc();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dly_done: got %b want 1", done); end
  endtask

  task test_backpressure();
    int base;
    load_default();
    do_reset();
    tx_ready = 1'b0; spi_busy = 1'b0;
    base = hs_cnt;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hCB || tx_dc !== 1'b0 || rom_addr !== 2'd0) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b data=%h dc=%b addr=%0d want 1 cb 0 0", i, tx_valid, tx_data, tx_dc, rom_addr);
      end
    end
    tx_ready = 1'b1;
    cyc();
    checks++; if (tx_valid !== 1'b0 || rom_addr !== 2'd1) begin errors++; $display("FAIL bp_advance: got valid=%b addr=%0d want 0 1", tx_valid, rom_addr); end
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (done !== 1'b1 || rom_addr !== 2'd2) begin errors++; $display("FAIL bp_done: got done=%b addr=%0d want 1 2", done, rom_addr); end
    checks++; if (hs_cnt - base !== 3) begin errors++; $display("FAIL bp_handshakes: got %0d want 3", hs_cnt - base); end
  endtask

  task test_flush_wait();
    load_default();
    do_reset();
    tx_ready = 1'b1; spi_busy = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    for (int i = 1; i <= 10; i++) begin
      cyc();
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_hold%0d: got done=%b busy=%b want 0 1", i, done, busy); end
    end
    spi_busy = 1'b0;
    cyc();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_done: got done=%b busy=%b want 1 0", done, busy); end
  endtask

  task test_abort();
    load_default();
    rom[0] = {8'd100, 1'b0, 8'h11};
    do_reset();
    tx_ready = 1'b1; spi_busy = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin errors++; $display("FAIL abort_send0: got valid=%b data=%h want 1 11", tx_valid, tx_data); end
    for (int i = 0; i < 20; i++) cyc();
    abort = 1'b1; cyc(); abort = 1'b0;
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || rom_addr !== 2'd0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b valid=%b addr=%0d done=%b want 0 0 0 0", busy, tx_valid, rom_addr, done);
    end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stay: got busy=%b want 0", busy); end
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h11 || rom_addr !== 2'd0) begin
      errors++; $display("FAIL abort_replay: got valid=%b data=%h addr=%0d want 1 11 0", tx_valid, tx_data, rom_addr);
    end
    abort = 1'b1; start = 1'b1; cyc(); abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL abort_wins: got busy=%b valid=%b want 0 0", busy, tx_valid); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_wins_hold: got busy=%b want 0", busy); end
    load_default();
  endtask

  task test_rst_in_send();
    load_default();
    rom[0] = {8'd0, 1'b1, 8'hCB};
    do_reset();
    tx_ready = 1'b0; spi_busy = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    checks++; if (tx_valid !== 1'b1 || tx_dc !== 1'b1) begin errors++; $display("FAIL rst_pre_send: got valid=%b dc=%b want 1 1", tx_valid, tx_dc); end
    rst = 1'b1; start = 1'b1;
    cyc();
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 2'd0 || tx_data !== 8'h00 || tx_dc !== 1'b0) begin
      errors++; $display("FAIL rst_send: got valid=%b busy=%b done=%b addr=%0d data=%h dc=%b want all 0", tx_valid, busy, done, rom_addr, tx_data, tx_dc);
    end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_ignored: got busy=%b want 0", busy); end
    rst = 1'b0; start = 1'b0; tx_ready = 1'b1;
    cyc();
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL rst_release: got busy=%b valid=%b want 0 0", busy, tx_valid); end
    load_default();
  endtask

  task test_single_entry();
    rom_data1 = {8'd3, 1'b1, 8'h77};
    do_reset();
    tx_ready = 1'b1; spi_busy = 1'b0;
    start1 = 1'b1; cyc(); start1 = 1'b0;
    checks++; if (busy1 !== 1'b1 || tx_valid1 !== 1'b0) begin errors++; $display("FAIL one_fetch: got busy=%b valid=%b want 1 0", busy1, tx_valid1); end
    cyc();
    checks++; if (tx_valid1 !== 1'b1 || tx_data1 !== 8'h77 || tx_dc1 !== 1'b1 || rom_addr1 !== 1'b0) begin
      errors++; $display("FAIL one_send: got valid=%b data=%h dc=%b addr=%0d want 1 77 1 0", tx_valid1, tx_data1, tx_dc1, rom_addr1);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (tx_valid1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++; $display("FAIL one_wait h+%0d: got valid=%b busy=%b done=%b want 0 1 0", i, tx_valid1, busy1, done1);
      end
    end
    cyc();
    checks++; if (done1 !== 1'b1 || busy1 !== 1'b0 || rom_addr1 !== 1'b0) begin
      errors++; $display("FAIL one_done: got done=%b busy=%b addr=%0d want 1 0 0", done1, busy1, rom_addr1);
    end
  endtask

  initial begin
    load_default();
    test_reset();
    test_basic_and_restart();
    test_delay();
    test_backpressure();
    test_flush_wait();
    test_abort();
    test_rst_in_send();
    test_single_entry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
